// File: rtl/sbox_share_ctrl.sv
// sbox_share_ctrl
// Time-multiplexes one external combinational AES S-box between the
// key-schedule requester (k_*) and the round datapath requester (d_*).
// An accepted word is pushed through the S-box one byte per cycle
// (byte 0 = bits 7:0 first). The substituted word is then returned
// together with a one-cycle valid pulse.
//
// Ports:
//   clk, rst                  rising-edge clock, async active-high reset
//   k_valid/k_word/k_ready    key-schedule request handshake
//   k_res/k_res_valid         substituted key word + one-cycle pulse
//   d_valid/d_word/d_ready    datapath request handshake
//   d_res/d_res_valid         substituted datapath word + one-cycle pulse
//   sbox_addr/sbox_data       shared S-box input byte / output byte
//   busy                      high while a word is in flight (RUN, DONE)
module sbox_share_ctrl #(
  parameter int NB        = 4,
  parameter bit KEY_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            k_valid,
  input  logic [8*NB-1:0] k_word,
  output logic            k_ready,
  output logic [8*NB-1:0] k_res,
  output logic            k_res_valid,
  input  logic            d_valid,
  input  logic [8*NB-1:0] d_word,
  output logic            d_ready,
  output logic [8*NB-1:0] d_res,
  output logic            d_res_valid,
  output logic [7:0]      sbox_addr,
  input  logic [7:0]      sbox_data,
  output logic            busy
);

  localparam int         W    = 8 * NB;
  localparam logic [2:0] LAST = 3'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] word_reg;
  logic [W-1:0] res_reg;
  logic [W-1:0] res_nxt;
  logic [2:0]   idx;
  logic         owner_key;  // 1: word in flight belongs to key requester
  logic         last_key;   // 1: most recent grant went to key requester

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    k_ready     = 1'b0;
    d_ready     = 1'b0;
    k_res_valid = 1'b0;
    d_res_valid = 1'b0;
    busy        = 1'b0;
    sbox_addr   = '0;
    res_nxt     = res_reg;
    case (state)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        k_ready = k_valid & (~d_valid | ~last_key);
        d_ready = d_valid & (~k_valid | last_key);
        if (k_ready | d_ready) state_nxt = RUN;
      end
      RUN: begin
        busy                 = 1'b1;
        sbox_addr            = word_reg[8*idx +: 8];
        res_nxt[8*idx +: 8]  = sbox_data;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        k_res_valid = owner_key;
        d_res_valid = ~owner_key;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_reg  <= '0;
      res_reg   <= '0;
      idx       <= '0;
      owner_key <= 1'b0;
      last_key  <= ~KEY_FIRST;
      k_res     <= '0;
      d_res     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (k_ready | d_ready) begin
            word_reg  <= k_ready ? k_word : d_word;
            owner_key <= k_ready;
            last_key  <= k_ready;
            idx       <= '0;
          end
        end
        RUN: begin
          res_reg <= res_nxt;
          idx     <= idx + 3'd1;
          // The owner's result register is loaded on the edge into DONE
          // (including the last byte) so it is already valid while the
          // res_valid pulse is high.
          if (idx == LAST) begin
            if (owner_key) k_res <= res_nxt;
            else           d_res <= res_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
module tb_sbox_share_ctrl;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        k_valid, d_valid, k_ready, d_ready;
  logic [31:0] k_word, d_word, k_res, d_res;
  logic        k_res_valid, d_res_valid, busy;
  logic [7:0]  sbox_addr, sbox_data;

  logic        k_valid1, d_valid1, k_ready1, d_ready1;
  logic [7:0]  k_word1, d_word1, k_res1, d_res1;
  logic        k_res_valid1, d_res_valid1, busy1;
  logic [7:0]  sbox_addr1, sbox_data1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] w;
    int          c;
  } exp_t;

  exp_t kq[$];
  exp_t dq[$];
  exp_t kq1[$];
  exp_t dq1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference AES S-box: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] r, p, e;
    r = 8'h01; p = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] word_sub(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_f(w[8*i +: 8]);
    return r;
  endfunction

  assign sbox_data  = sbox_f(sbox_addr);
  assign sbox_data1 = sbox_f(sbox_addr1);

  sbox_share_ctrl #(.NB(NB), .KEY_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .k_valid(k_valid), .k_word(k_word), .k_ready(k_ready),
    .k_res(k_res), .k_res_valid(k_res_valid),
    .d_valid(d_valid), .d_word(d_word), .d_ready(d_ready),
    .d_res(d_res), .d_res_valid(d_res_valid),
    .sbox_addr(sbox_addr), .sbox_data(sbox_data), .busy(busy)
  );

  sbox_share_ctrl #(.NB(1), .KEY_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .k_valid(k_valid1), .k_word(k_word1), .k_ready(k_ready1),
    .k_res(k_res1), .k_res_valid(k_res_valid1),
    .d_valid(d_valid1), .d_word(d_word1), .d_ready(d_ready1),
    .d_res(d_res1), .d_res_valid(d_res_valid1),
    .sbox_addr(sbox_addr1), .sbox_data(sbox_data1), .busy(busy1)
  );

  // Scoreboard monitors: pop an expectation on every result pulse and
  // check both the value and the cycle it arrived in.
  always @(negedge clk) begin
    exp_t e;
    if (k_res_valid) begin
      n_checks++;
      if (kq.size() == 0) begin
        n_fail++;
        $display("FAIL k_unexpected: k_res_valid=1 k_res=%h, required no pulse", k_res);
      end else begin
        e = kq.pop_front();
        if (k_res !== e.w || cyc != e.c) begin
          n_fail++;
          $display("FAIL k_result: got %h at cycle %0d, required %h at cycle %0d", k_res, cyc, e.w, e.c);
        end
      end
    end
    if (d_res_valid) begin
      n_checks++;
      if (dq.size() == 0) begin
        n_fail++;
        $display("FAIL d_unexpected: d_res_valid=1 d_res=%h, required no pulse", d_res);
      end else begin
        e = dq.pop_front();
        if (d_res !== e.w || cyc != e.c) begin
          n_fail++;
          $display("FAIL d_result: got %h at cycle %0d, required %h at cycle %0d", d_res, cyc, e.w, e.c);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (k_res_valid1) begin
      n_checks++;
      if (kq1.size() == 0) begin
        n_fail++;
        $display("FAIL k1_unexpected: k_res_valid=1 k_res=%h, required no pulse", k_res1);
      end else begin
        e = kq1.pop_front();
        if (k_res1 !== e.w[7:0] || cyc != e.c) begin
          n_fail++;
          $display("FAIL k1_result: got %h at cycle %0d, required %h at cycle %0d", k_res1, cyc, e.w[7:0], e.c);
        end
      end
    end
    if (d_res_valid1) begin
      n_checks++;
      if (dq1.size() == 0) begin
        n_fail++;
        $display("FAIL d1_unexpected: d_res_valid=1 d_res=%h, required no pulse", d_res1);
      end else begin
        e = dq1.pop_front();
        if (d_res1 !== e.w[7:0] || cyc != e.c) begin
          n_fail++;
          $display("FAIL d1_result: got %h at cycle %0d, required %h at cycle %0d", d_res1, cyc, e.w[7:0], e.c);
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      if (!busy && !busy1 && kq.size() == 0 && dq.size() == 0 &&
          kq1.size() == 0 && dq1.size() == 0) done = 1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: pending k=%0d d=%0d k1=%0d d1=%0d busy=%b, required all 0",
               name, kq.size(), dq.size(), kq1.size(), dq1.size(), busy);
      kq.delete(); dq.delete(); kq1.delete(); dq1.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    k_valid = 0; d_valid = 0; k_word = '0; d_word = '0;
    k_valid1 = 0; d_valid1 = 0; k_word1 = '0; d_word1 = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (k_ready !== 0 || d_ready !== 0 || busy !== 0 || k_res !== 0 || d_res !== 0 ||
        sbox_addr !== 0 || k_res_valid !== 0 || d_res_valid !== 0) begin
      n_fail++;
      $display("FAIL reset_state: kr=%b dr=%b busy=%b kres=%h dres=%h addr=%h kv=%b dv=%b, required all 0",
               k_ready, d_ready, busy, k_res, d_res, sbox_addr, k_res_valid, d_res_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_key_word();
    exp_t e;
    logic [7:0] ea [4];
    ea[0] = 8'h00; ea[1] = 8'h01; ea[2] = 8'hff; ea[3] = 8'h53;
    @(negedge clk);
    k_valid = 1; k_word = 32'h53ff0100; #1;
    n_checks++;
    if (k_ready !== 1 || d_ready !== 0) begin
      n_fail++;
      $display("FAIL key_ready: k_ready=%b d_ready=%b, required 1 0", k_ready, d_ready);
    end
    e.w = 32'hed167c63; e.c = cyc + 1 + NB; kq.push_back(e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) k_valid = 0;
      #1;
      n_checks++;
      if (sbox_addr !== ea[i] || busy !== 1 || k_ready !== 0) begin
        n_fail++;
        $display("FAIL key_addr%0d: addr=%h busy=%b k_ready=%b, required %h 1 0",
                 i, sbox_addr, busy, k_ready, ea[i]);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (sbox_addr !== 8'h00 || busy !== 1) begin
      n_fail++;
      $display("FAIL key_done_addr: addr=%h busy=%b, required 00 1", sbox_addr, busy);
    end
    wait_drain("key_word");
  endtask

  task automatic test_data_zero();
    exp_t e;
    logic [31:0] prev_k;
    bit got = 0;
    prev_k = k_res;
    @(negedge clk);
    d_valid = 1; d_word = 32'h0; #1;
    n_checks++;
    if (d_ready !== 1 || k_ready !== 0) begin
      n_fail++;
      $display("FAIL data_ready: d_ready=%b k_ready=%b, required 1 0", d_ready, k_ready);
    end
    e.w = 32'h63636363; e.c = cyc + 1 + NB; dq.push_back(e);
    @(negedge clk); d_valid = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (d_res_valid) begin
        got = 1;
        n_checks++;
        if (k_res !== prev_k) begin
          n_fail++;
          $display("FAIL data_k_hold: k_res=%h, required %h", k_res, prev_k);
        end
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL data_timeout: d_res_valid=0, required a pulse");
    end
    wait_drain("data_zero");
  endtask

  task automatic test_word_change();
    exp_t e;
    @(negedge clk);
    k_valid = 1; k_word = 32'hcf3c4f00; #1;
    n_checks++;
    if (k_ready !== 1) begin
      n_fail++;
      $display("FAIL change_ready: k_ready=%b, required 1", k_ready);
    end
    e.w = 32'h8aeb8463; e.c = cyc + 1 + NB; kq.push_back(e);
    @(negedge clk);
    k_valid = 0; k_word = 32'hffffffff;
    wait_drain("word_change");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int gi = 0;
    int last_c = -1;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    k_valid = 1; d_valid = 1;
    for (int i = 0; i < 4 * (NB + 2); i++) begin
      if (i > 0) @(negedge clk);
      k_word = $urandom; d_word = $urandom; #1;
      if (k_ready || d_ready) begin
        n_checks++;
        if ((k_ready && d_ready) || (k_ready != (gi % 2 == 0)) ||
            (last_c >= 0 && cyc - last_c != NB + 2)) begin
          n_fail++;
          $display("FAIL b2b_grant%0d: k_ready=%b d_ready=%b spacing=%0d, required key=%b spacing=%0d",
                   gi, k_ready, d_ready, cyc - last_c, gi % 2 == 0, NB + 2);
        end
        e.c = cyc + 1 + NB;
        if (k_ready) begin e.w = word_sub(k_word); kq.push_back(e); end
        else begin e.w = word_sub(d_word); dq.push_back(e); end
        last_c = cyc;
        gi++;
      end
    end
    @(negedge clk);
    k_valid = 0; d_valid = 0;
    n_checks++;
    if (gi != 4) begin
      n_fail++;
      $display("FAIL b2b_count: grants=%0d, required 4", gi);
    end
    wait_drain("back_to_back");
  endtask

  task automatic test_abort();
    exp_t e;
    @(negedge clk);
    k_valid = 1; k_word = 32'h0badf00d; #1;
    n_checks++;
    if (k_ready !== 1) begin
      n_fail++;
      $display("FAIL abort_ready: k_ready=%b, required 1", k_ready);
    end
    @(negedge clk); k_valid = 0;
    @(negedge clk); #1;
    n_checks++;
    if (sbox_addr !== 8'hf0 || busy !== 1) begin
      n_fail++;
      $display("FAIL abort_run2: addr=%h busy=%b, required f0 1", sbox_addr, busy);
    end
    rst = 1; #1;
    n_checks++;
    if (busy !== 0 || k_res !== 0 || d_res !== 0 || sbox_addr !== 0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b k_res=%h d_res=%h addr=%h, required 0",
               busy, k_res, d_res, sbox_addr);
    end
    @(negedge clk); rst = 0;
    repeat (8) @(negedge clk);
    k_valid = 1; k_word = $urandom; #1;
    n_checks++;
    if (k_ready !== 1) begin
      n_fail++;
      $display("FAIL abort_next_ready: k_ready=%b, required 1", k_ready);
    end
    e.w = word_sub(k_word); e.c = cyc + 1 + NB; kq.push_back(e);
    @(negedge clk); k_valid = 0;
    wait_drain("abort");
  endtask

  task automatic test_nb1();
    exp_t e;
    @(negedge clk);
    d_valid1 = 1; d_word1 = 8'h53; #1;
    n_checks++;
    if (d_ready1 !== 1) begin
      n_fail++;
      $display("FAIL nb1_ready: d_ready=%b, required 1", d_ready1);
    end
    e.w = 32'h000000ed; e.c = cyc + 2; dq1.push_back(e);
    @(negedge clk); d_valid1 = 0;
    wait_drain("nb1_data");
    @(negedge clk);
    k_valid1 = 1; k_word1 = 8'($urandom); #1;
    e.w = {24'h0, sbox_f(k_word1)}; e.c = cyc + 2; kq1.push_back(e);
    @(negedge clk); k_valid1 = 0;
    wait_drain("nb1_key");
  endtask

  initial begin
    test_reset();
    test_key_word();
    test_data_zero();
    test_word_change();
    test_back_to_back();
    test_abort();
    test_nb1();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
